// File: rtl/convolution_layer_sequencer_pkg.sv
// Shared widths and FSM encoding for the convolution layer sequencer.
// convolution_layer imports the same derived widths so both sides stay in step.
package convolution_layer_sequencer_pkg;

  localparam int default_matrix_width  = 9;
  localparam int default_matrix_height = 16;
  localparam int default_kernel_width  = 3;
  localparam int default_kernel_height = 3;
  localparam int default_data_size     = 32;

  function automatic int out_width(input int matrix_width, input int kernel_width);
    return matrix_width - kernel_width + 1;
  endfunction

  // Row counters must hold the full height, not just height-1.
  function automatic int row_bits(input int matrix_height);
    return $clog2(matrix_height + 1);
  endfunction

  function automatic int addr_bits(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  localparam int default_out_width = out_width(default_matrix_width, default_kernel_width);
  localparam int default_row_bits  = row_bits(default_matrix_height);
  localparam int default_kaddr_bits = addr_bits(default_kernel_height);

  typedef enum logic [2:0] {
    st_idle,
    st_prime,
    st_stream,
    st_drain,
    st_done
  } seq_state_t;

endpackage

// File: rtl/convolution_layer_sequencer_if.sv
// Control, row-memory, layer and result-memory signals of the sequencer.
// master is the sequencer side; slave is the surrounding engine.
interface convolution_layer_sequencer_if
  import convolution_layer_sequencer_pkg::*;
  #(
    parameter int max_input_matrix_width  = default_matrix_width,
    parameter int max_input_matrix_height = default_matrix_height,
    parameter int max_kernel_width        = default_kernel_width,
    parameter int max_kernel_height       = default_kernel_height,
    parameter int data_size               = default_data_size
  );

  localparam int ow  = out_width(max_input_matrix_width, max_kernel_width);
  localparam int rw  = row_bits(max_input_matrix_height);
  localparam int kaw = addr_bits(max_kernel_height);

  logic                                         start;
  logic [rw-1:0]                                cfg_in_height;
  logic                                         busy;
  logic                                         done;
  logic                                         cfg_error;
  logic [kaw-1:0]                               k_addr;
  logic [data_size*max_kernel_width-1:0]        k_data;
  logic [rw-1:0]                                m_addr;
  logic [data_size*max_input_matrix_width-1:0]  m_data;
  logic                                         conv_enable;
  logic [data_size*max_kernel_width-1:0]        conv_kernel;
  logic [data_size*max_input_matrix_width-1:0]  conv_matrix;
  logic [data_size*ow-1:0]                      conv_result;
  logic                                         out_we;
  logic [rw-1:0]                                out_addr;
  logic [data_size*ow-1:0]                      out_data;

  modport master (
    input  start, cfg_in_height, k_data, m_data, conv_result,
    output busy, done, cfg_error, k_addr, m_addr,
           conv_enable, conv_kernel, conv_matrix,
           out_we, out_addr, out_data
  );

  modport slave (
    output start, cfg_in_height, k_data, m_data, conv_result,
    input  busy, done, cfg_error, k_addr, m_addr,
           conv_enable, conv_kernel, conv_matrix,
           out_we, out_addr, out_data
  );

endinterface

// File: rtl/convolution_layer_sequencer.sv
// Frame controller for convolution_layer: primes the layer, streams kernel and
// matrix rows from synchronous-read memories, and writes each valid result row.
module convolution_layer_sequencer
  import convolution_layer_sequencer_pkg::*;
  #(
    parameter int max_input_matrix_width  = default_matrix_width,
    parameter int max_input_matrix_height = default_matrix_height,
    parameter int max_kernel_width        = default_kernel_width,
    parameter int max_kernel_height       = default_kernel_height,
    parameter int data_size               = default_data_size
  ) (
    input logic clk,
    input logic rst_n,
    convolution_layer_sequencer_if.master bus
  );

  localparam int ow  = out_width(max_input_matrix_width, max_kernel_width);
  localparam int rw  = row_bits(max_input_matrix_height);
  localparam int kaw = addr_bits(max_kernel_height);

  localparam logic [rw-1:0] kh_rows    = rw'(max_kernel_height);
  localparam logic [rw-1:0] max_height = rw'(max_input_matrix_height);

  localparam logic [data_size*max_kernel_width-1:0]       kernel_zero = '0;
  localparam logic [data_size*max_input_matrix_width-1:0] matrix_zero = '0;
  localparam logic [data_size*ow-1:0]                     result_zero = '0;

  seq_state_t    state;
  logic [rw-1:0] height;
  logic [rw-1:0] row;
  logic [rw-1:0] row_next;
  logic [rw-1:0] row_ahead;
  logic          start_legal;

  // row_ahead is the row whose read must be issued now so its data lands
  // exactly when the stream reaches it (1-cycle memory latency).
  always_comb begin
    row_next    = row + rw'(1);
    row_ahead   = row + rw'(2);
    start_legal = (bus.cfg_in_height >= kh_rows) && (bus.cfg_in_height <= max_height);
  end

  // Memory data is passed straight to the layer; kernel rows beyond KH are
  // forced to zero so the layer only ever loads the real kernel.
  assign bus.conv_matrix = (state == st_stream) ? bus.m_data : matrix_zero;
  assign bus.conv_kernel = ((state == st_stream) && (row < kh_rows)) ? bus.k_data : kernel_zero;
  assign bus.out_data    = bus.out_we ? bus.conv_result : result_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= st_idle;
      height          <= '0;
      row             <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.cfg_error   <= 1'b0;
      bus.conv_enable <= 1'b0;
      bus.k_addr      <= '0;
      bus.m_addr      <= '0;
      bus.out_we      <= 1'b0;
      bus.out_addr    <= '0;
    end else begin
      bus.done      <= 1'b0;
      bus.cfg_error <= 1'b0;
      bus.out_we    <= 1'b0;
      case (state)
        st_idle: begin
          if (bus.start) begin
            if (start_legal) begin
              height          <= bus.cfg_in_height;
              row             <= '0;
              bus.busy        <= 1'b1;
              bus.conv_enable <= 1'b1;
              bus.k_addr      <= '0;
              bus.m_addr      <= '0;
              state           <= st_prime;
            end else begin
              bus.cfg_error <= 1'b1;
            end
          end
        end
        st_prime: begin
          row        <= '0;
          bus.m_addr <= (rw'(1) < height) ? rw'(1) : '0;
          bus.k_addr <= (max_kernel_height > 1) ? kaw'(1) : '0;
          state      <= st_stream;
        end
        st_stream: begin
          if (row == height - rw'(1)) begin
            // The last row's result is ready during DRAIN, after enable drops.
            bus.conv_enable <= 1'b0;
            bus.out_we      <= 1'b1;
            bus.out_addr    <= height - kh_rows;
            bus.k_addr      <= '0;
            bus.m_addr      <= '0;
            state           <= st_drain;
          end else begin
            row        <= row_next;
            bus.m_addr <= (row_ahead < height) ? row_ahead : '0;
            bus.k_addr <= (row_ahead < kh_rows) ? kaw'(row_ahead) : '0;
            if (row_next >= kh_rows) begin
              bus.out_we   <= 1'b1;
              bus.out_addr <= row_next - kh_rows;
            end
          end
        end
        st_drain: begin
          bus.done <= 1'b1;
          state    <= st_done;
        end
        st_done: begin
          bus.busy <= 1'b0;
          state    <= st_idle;
        end
        default: begin
          bus.busy        <= 1'b0;
          bus.conv_enable <= 1'b0;
          state           <= st_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_convolution_layer_sequencer.sv
// Bench for convolution_layer_sequencer: row memories, a behavioural layer and
// a frame-level reference computed directly from the memory contents.
module tb_convolution_layer_sequencer;
  import convolution_layer_sequencer_pkg::*;

  localparam int dw   = default_data_size;
  localparam int mw   = default_matrix_width;
  localparam int kw   = default_kernel_width;
  localparam int kh   = default_kernel_height;
  localparam int hmax = default_matrix_height;
  localparam int ow   = default_out_width;
  localparam int rw   = default_row_bits;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  convolution_layer_sequencer_if #(
    .max_input_matrix_width(mw), .max_input_matrix_height(hmax),
    .max_kernel_width(kw), .max_kernel_height(kh), .data_size(dw)
  ) bus ();

  convolution_layer_sequencer #(
    .max_input_matrix_width(mw), .max_input_matrix_height(hmax),
    .max_kernel_width(kw), .max_kernel_height(kh), .data_size(dw)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [kw*dw-1:0] kmem [kh];
  logic [mw*dw-1:0] mmem [hmax];

  always @(posedge clk) begin
    bus.k_data <= kmem[bus.k_addr];
    bus.m_data <= mmem[bus.m_addr];
  end

  // Layer stand-in: clears on the first enabled edge, then slides a KH-row window.
  logic [kh*mw*dw-1:0] stub_win;
  logic [kh*kw*dw-1:0] stub_kern;
  int                  stub_loaded = 0;
  bit                  stub_active = 1'b0;

  function automatic logic [kh*mw*dw-1:0] shiftWindow(input logic [kh*mw*dw-1:0] win,
                                                      input logic [mw*dw-1:0] row_in);
    return {row_in, win[kh*mw*dw-1:mw*dw]};
  endfunction

  function automatic logic [kh*kw*dw-1:0] loadKernel(input logic [kh*kw*dw-1:0] kern,
                                                     input int loaded,
                                                     input logic [kw*dw-1:0] row_in);
    logic [kh*kw*dw-1:0] k = kern;
    if (loaded < kh) k[loaded*kw*dw +: kw*dw] = row_in;
    return k;
  endfunction

  function automatic logic [ow*dw-1:0] windowConv(input logic [kh*mw*dw-1:0] win,
                                                  input logic [kh*kw*dw-1:0] kern);
    logic [ow*dw-1:0] res = '0;
    for (int c = 0; c < ow; c++)
      for (int kr = 0; kr < kh; kr++)
        for (int kc = 0; kc < kw; kc++)
          res[c*dw +: dw] += kern[(kr*kw+kc)*dw +: dw] * win[(kr*mw+c+kc)*dw +: dw];
    return res;
  endfunction

  always @(posedge clk) begin
    if (bus.conv_enable && !stub_active) begin
      stub_active <= 1'b1;
      stub_loaded <= 0;
      stub_win    <= '0;
      stub_kern   <= '0;
    end else if (stub_active) begin
      stub_win        <= shiftWindow(stub_win, bus.conv_matrix);
      stub_kern       <= loadKernel(stub_kern, stub_loaded, bus.conv_kernel);
      stub_loaded     <= stub_loaded + 1;
      bus.conv_result <= windowConv(shiftWindow(stub_win, bus.conv_matrix),
                                    loadKernel(stub_kern, stub_loaded, bus.conv_kernel));
      if (!bus.conv_enable) stub_active <= 1'b0;
    end
  end

  // Reference: output row r, column c is the KH x KW dot product at matrix (r, c).
  function automatic logic [ow*dw-1:0] expectedRow(input int r);
    logic [ow*dw-1:0] acc = '0;
    for (int c = 0; c < ow; c++)
      for (int kr = 0; kr < kh; kr++)
        for (int kc = 0; kc < kw; kc++)
          acc[c*dw +: dw] += kmem[kr][kc*dw +: dw] * mmem[r+kr][(c+kc)*dw +: dw];
    return acc;
  endfunction

  int test_count = 0;
  int fail_count = 0;

  int               wr_addr [$];
  int               wr_cycle [$];
  logic [ow*dw-1:0] wr_data [$];
  int done_cycle, err_pulses, busy_cycles, enable_cycles;

  task automatic checkOutput(input string tag, input logic [319:0] observed,
                             input logic [319:0] expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic fillRandom(input int maxv);
    for (int r = 0; r < kh; r++)
      for (int c = 0; c < kw; c++) kmem[r][c*dw +: dw] = dw'($urandom_range(0, maxv));
    for (int r = 0; r < hmax; r++)
      for (int c = 0; c < mw; c++) mmem[r][c*dw +: dw] = dw'($urandom_range(0, maxv));
  endtask

  task automatic fillOnes();
    for (int r = 0; r < kh; r++)
      for (int c = 0; c < kw; c++) kmem[r][c*dw +: dw] = dw'(1);
    for (int r = 0; r < hmax; r++)
      for (int c = 0; c < mw; c++) mmem[r][c*dw +: dw] = dw'(1);
  endtask

  // Pulses start with height h, then records activity for each cycle after it.
  task automatic applyStimulus(input int h, input int extra_start_cyc, input int reset_cyc,
                               input int budget, input int tail);
    wr_addr.delete();
    wr_cycle.delete();
    wr_data.delete();
    done_cycle = -1;
    err_pulses = 0;
    busy_cycles = 0;
    enable_cycles = 0;
    @(negedge clk);
    bus.cfg_in_height = rw'(h);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.cfg_in_height = rw'($urandom_range(0, 31));
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (bus.out_we) begin
        wr_addr.push_back(int'(bus.out_addr));
        wr_cycle.push_back(cyc);
        wr_data.push_back(bus.out_data);
      end
      if (bus.cfg_error) err_pulses++;
      if (bus.busy) busy_cycles++;
      if (bus.conv_enable) enable_cycles++;
      if (bus.done) done_cycle = cyc;
      if (done_cycle > 0 && cyc >= done_cycle + tail) break;
      bus.start = (cyc == extra_start_cyc);
      rst_n = (cyc == reset_cyc) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic checkFrame(input string label, input int h);
    checkOutput({label, "/writes"}, wr_addr.size(), h - kh + 1);
    checkOutput({label, "/done_cycle"}, done_cycle, h + 3);
    checkOutput({label, "/busy_cycles"}, busy_cycles, h + 3);
    checkOutput({label, "/enable_cycles"}, enable_cycles, h + 1);
    checkOutput({label, "/cfg_error"}, err_pulses, 0);
    for (int i = 0; i < wr_addr.size(); i++) begin
      checkOutput($sformatf("%s/addr%0d", label, i), wr_addr[i], i);
      checkOutput($sformatf("%s/cycle%0d", label, i), wr_cycle[i], kh + 2 + i);
      checkOutput($sformatf("%s/data%0d", label, i), wr_data[i], expectedRow(i));
    end
  endtask

  task automatic checkRejected(input string label);
    checkOutput({label, "/cfg_error"}, err_pulses, 1);
    checkOutput({label, "/busy"}, busy_cycles, 0);
    checkOutput({label, "/enable"}, enable_cycles, 0);
    checkOutput({label, "/writes"}, wr_addr.size(), 0);
    checkOutput({label, "/done"}, done_cycle, -1);
  endtask

  initial begin
    logic [ow*dw-1:0] nines;
    logic [ow*dw-1:0] twos;
    int h;
    nines = {ow{dw'(9)}};
    twos  = {ow{dw'(2)}};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.cfg_in_height = '0;
    fillOnes();
    repeat (3) @(negedge clk);
    checkOutput("reset/busy", bus.busy, 0);
    checkOutput("reset/done", bus.done, 0);
    checkOutput("reset/cfg_error", bus.cfg_error, 0);
    checkOutput("reset/conv_enable", bus.conv_enable, 0);
    checkOutput("reset/out_we", bus.out_we, 0);
    checkOutput("reset/k_addr", bus.k_addr, 0);
    checkOutput("reset/m_addr", bus.m_addr, 0);
    checkOutput("reset/out_addr", bus.out_addr, 0);
    checkOutput("reset/out_data", bus.out_data, 0);
    checkOutput("reset/conv_kernel", bus.conv_kernel, 0);
    checkOutput("reset/conv_matrix", bus.conv_matrix, 0);
    rst_n = 1'b1;

    applyStimulus(5, 0, 0, 40, 2);
    checkFrame("ones_h5", 5);
    for (int i = 0; i < 3; i++) checkOutput($sformatf("ones_h5/nines%0d", i), wr_data[i], nines);

    for (int r = 0; r < kh; r++) kmem[r] = '0;
    kmem[1][dw +: dw] = dw'(1);
    for (int r = 0; r < hmax; r++)
      for (int c = 0; c < mw; c++) mmem[r][c*dw +: dw] = dw'(r + 1);
    applyStimulus(3, 0, 0, 40, 2);
    checkFrame("centre_h3", 3);
    checkOutput("centre_h3/twos", wr_data[0], twos);

    applyStimulus(2, 0, 0, 6, 0);
    checkRejected("bad_h2");
    applyStimulus(17, 0, 0, 6, 0);
    checkRejected("bad_h17");

    fillRandom(15);
    applyStimulus(6, 4, 0, 40, 4);
    checkFrame("restart_h6", 6);

    applyStimulus(8, 0, 4, 10, 0);
    checkOutput("abort_h8/writes", wr_addr.size(), 0);
    checkOutput("abort_h8/busy_cycles", busy_cycles, 4);
    checkOutput("abort_h8/enable_cycles", enable_cycles, 4);
    checkOutput("abort_h8/done", done_cycle, -1);
    fillOnes();
    applyStimulus(4, 0, 0, 40, 2);
    checkFrame("after_abort_h4", 4);
    checkOutput("after_abort_h4/nines0", wr_data[0], nines);
    checkOutput("after_abort_h4/nines1", wr_data[1], nines);

    fillRandom(15);
    applyStimulus(5, 0, 0, 40, 0);
    checkFrame("b2b_first", 5);
    for (int r = 0; r < kh; r++)
      for (int c = 0; c < kw; c++) kmem[r][c*dw +: dw] = dw'($urandom_range(16, 31));
    applyStimulus(5, 0, 0, 40, 2);
    checkFrame("b2b_second", 5);

    for (int n = 0; n < 4; n++) begin
      fillRandom(255);
      h = int'($urandom_range(kh, hmax));
      applyStimulus(h, 0, 0, 40, 1);
      checkFrame($sformatf("rand%0d_h%0d", n, h), h);
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
